// File: rtl/cic_comp_fir_pkg.sv
// ============================================================================
// Package : cic_comp_pkg
// Desc    : Shared constants, inverse-sinc coefficients and FSM state type for
//           the CIC droop-compensation FIR.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cic_comp_pkg;

  localparam int COMP_NTAPS     = 15;
  localparam int COMP_COEF_FRAC = 10;
  localparam int COMP_COEF_W    = 12;
  localparam int COMP_IDX_W     = $clog2(COMP_NTAPS);

  // Symmetric inverse-sinc taps: sum = 1024 (unity DC), |Nyquist gain| = 1184/1024.
  localparam logic signed [COMP_COEF_W-1:0] COMP_COEF [COMP_NTAPS] = '{
    12'sd2,    -12'sd4,   12'sd6,  -12'sd10,  12'sd16, -12'sd28, -12'sd64,
    12'sd1188,
    -12'sd64,  -12'sd28,  12'sd16, -12'sd10,  12'sd6,  -12'sd4,   12'sd2
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2
  } comp_state_t;

  // Taps beyond the table read as zero so longer builds stay well defined.
  function automatic logic signed [COMP_COEF_W-1:0] comp_coef(input int k);
    logic [COMP_IDX_W-1:0] idx;
    idx = k[COMP_IDX_W-1:0];
    if (k >= 0 && k < COMP_NTAPS) return COMP_COEF[idx];
    return '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cic_comp_fir_if.sv
// ============================================================================
// Interface : cic_comp_fir_if
// Desc      : Sample-side signals between the CIC decimator, the compensation
//             FIR and its consumer. Optional sat flag under COMP_SAT_EN.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface cic_comp_fir_if #(
  parameter int DATA_W = 8
) ();

  logic                     d_clk_in;
  logic signed [DATA_W-1:0] d_in;
  logic signed [DATA_W-1:0] d_out;
  logic                     d_valid;
  logic                     busy;
  logic                     overrun;
`ifdef COMP_SAT_EN
  logic                     sat;
`endif

  modport master (
    output d_clk_in, d_in,
`ifdef COMP_SAT_EN
    input  sat,
`endif
    input  d_out, d_valid, busy, overrun
  );

  modport slave (
    input  d_clk_in, d_in,
`ifdef COMP_SAT_EN
    output sat,
`endif
    output d_out, d_valid, busy, overrun
  );

endinterface

`default_nettype wire

// File: rtl/cic_comp_fir.sv
// ============================================================================
// Module : cic_comp_fir
// Desc   : Serial-MAC FIR compensating CIC sinc droop, one tap per clk.
//          Define COMP_SAT_EN for output saturation and the sticky sat flag;
//          otherwise the rounded result wraps to DATA_W bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int NTAPS     = COMP_NTAPS,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = COMP_COEF_W,
  parameter int COEF_FRAC = COMP_COEF_FRAC,
  parameter int ACC_W     = 26
) (
  input  wire logic      clk,
  input  wire logic      rst,
  cic_comp_fir_if.slave  bus
);

  localparam int                      TAP_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int                      PROD_W = DATA_W + COEF_W;
  localparam logic [TAP_W-1:0]        C_LAST = TAP_W'(NTAPS - 1);
  localparam logic signed [ACC_W-1:0] C_HALF = ACC_W'(2 ** (COEF_FRAC - 1));
`ifdef COMP_SAT_EN
  localparam logic signed [ACC_W-1:0] C_MAX  = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] C_MIN  = -ACC_W'(2 ** (DATA_W - 1));
`endif

  comp_state_t              r_state;
  logic                     r_dq;
  logic [TAP_W-1:0]         r_wr_ptr;
  logic [TAP_W-1:0]         r_rd_ptr;
  logic [TAP_W-1:0]         r_tap;
  logic signed [DATA_W-1:0] r_line [NTAPS];
  logic signed [ACC_W-1:0]  r_acc;

  logic                     w_strobe;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] w_out;
`ifdef COMP_SAT_EN
  logic signed [ACC_W-1:0]  w_r;
  logic                     w_clip;
`endif

  always_comb begin
    w_strobe = bus.d_clk_in & ~r_dq;
    w_coef   = COEF_W'(comp_coef(int'(r_tap)));
    w_prod   = PROD_W'(r_line[r_rd_ptr]) * PROD_W'(w_coef);
    w_sum    = r_acc + C_HALF;
`ifdef COMP_SAT_EN
    w_r      = w_sum >>> COEF_FRAC;
    w_clip   = 1'b0;
    w_out    = DATA_W'(w_r);
    if (w_r > C_MAX) begin
      w_out  = DATA_W'(C_MAX);
      w_clip = 1'b1;
    end else if (w_r < C_MIN) begin
      w_out  = DATA_W'(C_MIN);
      w_clip = 1'b1;
    end
`else
    w_out    = DATA_W'(w_sum >>> COEF_FRAC);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dq        <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_tap       <= '0;
      r_acc       <= '0;
      bus.d_out   <= '0;
      bus.d_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
`ifdef COMP_SAT_EN
      bus.sat     <= 1'b0;
`endif
      for (int i = 0; i < NTAPS; i++) r_line[i] <= '0;
    end else begin
      r_dq        <= bus.d_clk_in;
      bus.d_valid <= 1'b0;
      // Any strobe outside IDLE (including the ROUND cycle) is dropped.
      if (w_strobe && r_state != IDLE) bus.overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_strobe) begin
            r_line[r_wr_ptr] <= bus.d_in;
            r_rd_ptr         <= r_wr_ptr;
            r_tap            <= '0;
            r_acc            <= '0;
            bus.busy         <= 1'b1;
            r_state          <= MAC;
          end
        end
        MAC: begin
          r_acc    <= r_acc + ACC_W'(w_prod);
          r_rd_ptr <= (r_rd_ptr == '0) ? C_LAST : r_rd_ptr - TAP_W'(1);
          if (r_tap == C_LAST) r_state <= ROUND;
          else                 r_tap   <= r_tap + TAP_W'(1);
        end
        ROUND: begin
          bus.d_out   <= w_out;
          bus.d_valid <= 1'b1;
          bus.busy    <= 1'b0;
          r_wr_ptr    <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + TAP_W'(1);
`ifdef COMP_SAT_EN
          if (w_clip) bus.sat <= 1'b1;
`endif
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cic_comp_fir.sv
// ============================================================================
// Module : tb_cic_comp_fir
// Desc   : Table-driven self-checking bench for cic_comp_fir (COMP_SAT_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cic_comp_fir;

  typedef struct {
    logic signed [7:0] din;
    logic signed [7:0] exp;
    bit                chk;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   nerr = 0;
  int   nchk = 0;

  always #5 clk = ~clk;

  cic_comp_fir_if #(.DATA_W(8)) bus ();

  cic_comp_fir #(
    .NTAPS(15), .DATA_W(8), .COEF_W(12), .COEF_FRAC(10), .ACC_W(26)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Hand-computed: impulse 100 -> (100*c[n]+512)>>>10, DC 50 from a zeroed line.
  int imp_exp [15] = '{0, 0, 1, -1, 2, -3, -6, 116, -6, -3, 2, -1, 1, 0, 0};
  int dc_exp  [20] = '{0, 0, 0, 0, 0, -1, -4, 54, 51, 50, 50, 50, 50, 50, 50,
                       50, 50, 50, 50, 50};
  vec_t imp_v [15];
  vec_t dc_v  [20];
  vec_t nyq_v [20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.d_clk_in = 1'b0;
    bus.d_in = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic signed [7:0] s);
    bus.d_in     = s;
    bus.d_clk_in = 1'b1;
    tick();
    bus.d_clk_in = 1'b0;
  endtask

  // lat counts clk cycles from the strobe cycle to the d_valid cycle.
  task automatic wait_valid(output logic signed [7:0] y, output int lat);
    lat = 1;
    y   = '0;
    while (!bus.d_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (bus.d_valid) y = bus.d_out;
    else begin
      nchk++;
      nerr++;
      $display("FAIL d_valid_timeout: got none expected pulse within 40 cycles");
    end
  endtask

  task automatic run_sample(input logic signed [7:0] s, output logic signed [7:0] y,
                            output int lat);
    send(s);
    wait_valid(y, lat);
    repeat (4) tick();
  endtask

  task automatic fill(input logic signed [7:0] s, input int n);
    logic signed [7:0] y;
    int lat;
    for (int i = 0; i < n; i++) run_sample(s, y, lat);
  endtask

  task automatic run_dc(input string tag);
    logic signed [7:0] y;
    int lat;
    for (int i = 0; i < 20; i++) begin
      run_sample(dc_v[i].din, y, lat);
      if (dc_v[i].chk) check($sformatf("%s_out[%0d]", tag, i), y, dc_v[i].exp);
    end
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.d_valid) n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [7:0] y;
    int lat;
    int nv;

    for (int i = 0; i < 15; i++) imp_v[i] = '{din: (i == 0) ? 8'sd100 : 8'sd0,
                                             exp: 8'(imp_exp[i]), chk: 1'b1};
    for (int i = 0; i < 20; i++) dc_v[i] = '{din: 8'sd50, exp: 8'(dc_exp[i]), chk: 1'b1};
    for (int i = 0; i < 20; i++) begin
      nyq_v[i].din = (i % 2 == 0) ? 8'sd127 : -8'sd127;
`ifdef COMP_SAT_EN
      nyq_v[i].exp = (i % 2 == 0) ? -8'sd128 : 8'sd127;
`else
      nyq_v[i].exp = (i % 2 == 0) ? 8'sd109 : -8'sd109;
`endif
      nyq_v[i].chk = (i >= 14);
    end

    // Reset then idle
    rst = 1'b1;
    bus.d_clk_in = 1'b0;
    bus.d_in = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) rst = 1'b0;
      tick();
      check($sformatf("idle_d_out[%0d]", i),   bus.d_out,   0);
      check($sformatf("idle_d_valid[%0d]", i), bus.d_valid, 0);
      check($sformatf("idle_busy[%0d]", i),    bus.busy,    0);
      check($sformatf("idle_overrun[%0d]", i), bus.overrun, 0);
    end

    // DC gain
    do_reset();
    run_dc("dc");

    // Impulse response and latency
    do_reset();
    for (int i = 0; i < 15; i++) begin
      run_sample(imp_v[i].din, y, lat);
      if (imp_v[i].chk) check($sformatf("imp_out[%0d]", i), y, imp_v[i].exp);
      check($sformatf("imp_latency[%0d]", i), lat, 17);
    end

    // Strobe landing on the ROUND cycle is dropped
    do_reset();
    fill(8'sd50, 15);
    send(8'sd50);
    repeat (15) tick();
    check("round_busy", bus.busy, 1);
    bus.d_in = -8'sd100;
    bus.d_clk_in = 1'b1;
    tick();
    bus.d_clk_in = 1'b0;
    check("round_d_valid", bus.d_valid, 1);
    check("round_d_out", bus.d_out, 50);
    check("round_overrun", bus.overrun, 1);
    count_valid(25, nv);
    check("round_no_extra_pass", nv, 0);
    check("round_busy_after", bus.busy, 0);
    run_sample(8'sd50, y, lat);
    check("round_line_intact", y, 50);

    // Strobe 10 cycles into a pass is dropped, overrun sticky until rst
    send(8'sd50);
    repeat (9) tick();
    send(-8'sd100);
    wait_valid(y, lat);
    check("ovr_first_out", y, 50);
    check("ovr_flag", bus.overrun, 1);
    repeat (4) tick();
    run_sample(8'sd50, y, lat);
    check("ovr_line_intact", y, 50);
    check("ovr_sticky", bus.overrun, 1);
    do_reset();
    check("ovr_cleared", bus.overrun, 0);

    // Reset mid-pass aborts it and clears all history
    fill(8'sd100, 15);
    send(8'sd100);
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rstmid_d_out", bus.d_out, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_overrun", bus.overrun, 0);
    count_valid(30, nv);
    check("rstmid_no_valid", nv, 0);
    run_dc("rstmid_dc");

    // Nyquist stress
    do_reset();
    for (int i = 0; i < 20; i++) begin
      run_sample(nyq_v[i].din, y, lat);
      if (nyq_v[i].chk) check($sformatf("nyq_out[%0d]", i), y, nyq_v[i].exp);
    end
`ifdef COMP_SAT_EN
    check("nyq_sat", bus.sat, 1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
- Serial-MAC FIR that compensates the CIC decimator's sinc droop. It sits directly downstream of the CIC decimator and upstream of AM envelope detection.
- Consumes the decimator's 8-bit output sample and its output-rate clock flag. Runs entirely on the system clock, one tap per clk cycle.
- Emits one compensated 8-bit sample with a one-cycle valid strobe per input sample.

Parameters:
- NTAPS, 15, number of FIR taps; legal range 3..63.
- DATA_W, 8, input/output sample width (signed).
- COEF_W, 12, coefficient width (signed).
- COEF_FRAC, 10, fractional bits of the coefficients; 1.0 = 1024.
- ACC_W, 26, accumulator width; must be >= DATA_W + COEF_W + ceil(log2(NTAPS)).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- d_clk_in  in  1  decimator output-rate flag; level signal, generated in the clk domain.
- d_in  in  DATA_W  signed decimator output sample; stable from the clk edge after d_clk_in rises.
- d_out  out  DATA_W  signed compensated sample, registered.
- d_valid  out  1  one-clk pulse when d_out updates.
- busy  out  1  high while a MAC pass is in progress.
- overrun  out  1  sticky flag: an input strobe arrived while busy.

Behaviour:
- Reset values:
  - Outputs: d_out=0, d_valid=0, busy=0, overrun=0.
  - Internal: all NTAPS delay-line entries=0, write pointer=0, accumulator=0, state=IDLE, registered d_clk_in copy=0.
  - Reset asserted mid-pass aborts the pass; no d_valid is produced.
- Strobe detection:
  - d_clk_in is registered once (dq).
  - strobe = d_clk_in & ~dq, i.e. the rising edge.
  - No synchroniser: the source is the same clock domain.
- Sample capture: on a strobe in IDLE, d_in is written to the delay line at wr_ptr and the state moves to MAC.
- Delay line:
  - Circular buffer of NTAPS entries.
  - wr_ptr advances by 1 after each pass and wraps NTAPS-1 -> 0.
- State machine, IDLE -> MAC -> ROUND -> IDLE:
  - IDLE: busy=0; waits for a strobe.
  - MAC: NTAPS cycles, tap index k = 0..NTAPS-1.
    - acc += x[(wr_ptr - k) mod NTAPS] * COMP_COEF[k], full-precision signed product.
    - acc is cleared on entry.
  - ROUND: 1 cycle.
    - r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, arithmetic shift, round half up.
    - r is reduced to DATA_W bits (see Optional Feature) and registered to d_out.
    - d_valid=1 for this single cycle.
    - wr_ptr advances.
- Latency: strobe cycle to d_valid cycle = NTAPS + 2 clk cycles (17 at defaults).
- Throughput: the decimation ratio must be >= NTAPS + 3 clk cycles.
- Strobe while busy (MAC or ROUND): the sample is dropped, the delay line is unchanged, overrun is set and stays set until rst, and the current pass completes normally.
- A strobe in the same cycle as the ROUND->IDLE transition counts as busy and is dropped.
- A strobe coincident with rst is ignored.
- d_clk_in held high produces exactly one strobe.

Optional Feature:
- Macro: COMP_SAT_EN.
- Defined:
  - r is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], i.e. [-128, 127].
  - An extra output port sat (1 bit, sticky, reset 0) is set whenever clamping occurs.
- Not defined:
  - r is truncated to its low DATA_W bits (two's-complement wrap).
  - The sat port does not exist.

Decomposition:
- Package cic_comp_pkg holds:
  - COMP_NTAPS=15 and COMP_COEF_FRAC=10.
  - COMP_COEF, the 15-entry signed 12-bit inverse-sinc coefficient constant array: symmetric, summing to 1024 (unity DC gain), Nyquist gain > 1.
  - State enum type: IDLE, MAC, ROUND.
- No sub-module; delay line, MAC and FSM live in one module.

Test Plan:
1. Reset then idle: rst held 5 cycles, no strobes -> d_out=0, d_valid=0, busy=0, overrun=0 throughout.
2. DC gain: constant d_in=50, one strobe every 64 clk -> from the 15th output onward, d_out=50 exactly.
3. Impulse and latency:
   - Stimulus: d_in=100 for one strobe, 0 afterwards.
   - Output n (n=0..14) = round(100*COMP_COEF[n]/1024).
   - d_valid occurs exactly 17 clk after each strobe.
4. Overrun: two strobes 10 clk apart -> second sample dropped, overrun=1, the first pass's output is still correct, overrun stays 1 until rst.
5. Reset mid-pass: rst asserted 5 cycles into MAC -> no d_valid, all outputs 0. The next DC run (d_in=50) reaches 50 after 15 samples with no stale data.
6. Nyquist stress: alternating d_in=+127/-127.
   - With COMP_SAT_EN: d_out clamps to 127/-128 and sat=1.
   - Without it: d_out equals the low 8 bits of r.
